// File: rtl/prim_packer_v2_pkg.sv
// Shared types and unit-mask helpers for the packer.
package prim_packer_v2_pkg;

    typedef enum logic {
        FlushIdle  = 1'b0,
        FlushDrain = 1'b1
    } flush_state_e;

    // Widest unit mask the helpers handle; callers zero-extend into this.
    localparam int MaxUnits = 64;

    function automatic int unsigned count_ones(input logic [MaxUnits-1:0] m);
        int unsigned n = 0;
        for (int i = 0; i < MaxUnits; i++) begin
            if (m[i]) n++;
        end
        return n;
    endfunction

    // Index of the least significant set bit; 0 for an all-zero mask.
    function automatic int unsigned lowest_one(input logic [MaxUnits-1:0] m);
        int unsigned idx = 0;
        for (int i = MaxUnits - 1; i >= 0; i--) begin
            if (m[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

    // After dropping trailing zeros, a single run of ones has no carry overlap.
    function automatic logic is_contiguous(input logic [MaxUnits-1:0] m);
        logic [MaxUnits-1:0] sh;
        sh = m >> lowest_one(m);
        return (sh & (sh + MaxUnits'(1))) == '0;
    endfunction

endpackage

// File: rtl/prim_packer_v2_compact.sv
// Mask analysis: leading-one index, enabled-unit count and contiguity.
module prim_packer_v2_compact
    import prim_packer_v2_pkg::*;
#(
    parameter int NIn  = 4,
    parameter int IdxW = (NIn > 1) ? $clog2(NIn) : 1,
    parameter int CntW = $clog2(NIn + 1)
) (
    input  logic [NIn-1:0]  mask,
    output logic [IdxW-1:0] lead_idx,
    output logic [CntW-1:0] ones,
    output logic            contig
);

    if (NIn > MaxUnits) begin : g_too_wide
        $error("NIn exceeds the helper function width");
    end

    logic [MaxUnits-1:0] mask_ext;

    assign mask_ext = MaxUnits'(mask);
    assign lead_idx = IdxW'(lowest_one(mask_ext));
    assign ones     = CntW'(count_ones(mask_ext));
    assign contig   = is_contiguous(mask_ext);

endmodule

// File: rtl/prim_packer_v2.sv
// Unit-granular packer: appends masked input units into a shift store and
// emits OutW-wide words, with an explicit flush that drains the remnant.
module prim_packer_v2
    import prim_packer_v2_pkg::*;
#(
    parameter int InW   = 32,
    parameter int OutW  = 32,
    parameter int UnitW = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [InW-1:0]        data_i,
    input  logic [InW/UnitW-1:0]  mask_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [OutW-1:0]       data_o,
    output logic [OutW/UnitW-1:0] mask_o,
    output logic                  last_o,
    input  logic                  ready_i,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic                  empty_o,
    output logic                  err_o
);

    localparam int NIn  = InW / UnitW;
    localparam int NOut = OutW / UnitW;
    localparam int NTot = NIn + NOut;
    localparam int TotW = NTot * UnitW;
    localparam int PosW = $clog2(NTot + 1);
    localparam int IdxW = (NIn > 1) ? $clog2(NIn) : 1;
    localparam int CntW = $clog2(NIn + 1);
    localparam logic [PosW-1:0] NOutP = PosW'(NOut);

    if (InW % UnitW != 0) begin : g_bad_inw
        $error("InW must be a multiple of UnitW");
    end
    if (OutW % UnitW != 0) begin : g_bad_outw
        $error("OutW must be a multiple of UnitW");
    end

    flush_state_e    state_q, state_d;
    logic [TotW-1:0] store_q, store_d, store_app;
    logic [PosW-1:0] pos_q, pos_d, pos_app;
    logic            err_q, err_d;

    logic [IdxW-1:0] lead_idx;
    logic [CntW-1:0] ones;
    logic            contig;
    logic [InW-1:0]  bit_mask;
    logic [InW-1:0]  data_al;
    logic [TotW-1:0] data_ext;
    logic            ack_in, ack_out, draining;

    prim_packer_v2_compact #(
        .NIn  (NIn),
        .IdxW (IdxW),
        .CntW (CntW)
    ) u_compact (
        .mask     (mask_i),
        .lead_idx (lead_idx),
        .ones     (ones),
        .contig   (contig)
    );

    // Expand the unit mask to bits so disabled units never reach the store.
    for (genvar i = 0; i < NIn; i++) begin : g_bit_mask
        assign bit_mask[i*UnitW +: UnitW] = {UnitW{mask_i[i]}};
    end

    assign data_al  = (data_i & bit_mask) >> (int'(lead_idx) * UnitW);
    assign data_ext = TotW'(data_al);

    // Outputs are forced to their idle values while reset is asserted.
    assign draining = (state_q == FlushDrain);
    assign ready_o  = !rst_i && !draining && (pos_q <= NOutP);
    assign valid_o  = !rst_i && ((pos_q >= NOutP) || (draining && pos_q != '0));
    assign last_o   = valid_o && draining && (pos_q <= NOutP);
    assign empty_o  = rst_i || (pos_q == '0);
    assign err_o    = err_q && !rst_i;
    assign data_o   = rst_i ? '0 : store_q[OutW-1:0];
    assign ack_in   = valid_i && ready_o;
    assign ack_out  = valid_o && ready_i;

    // Units above pos_q are always zero, so mask_o is just a thermometer.
    for (genvar i = 0; i < NOut; i++) begin : g_mask_o
        assign mask_o[i] = !rst_i && (pos_q > PosW'(i));
    end

    // Append first, then shift out, so a simultaneous in/out loses nothing.
    always_comb begin
        store_app = store_q;
        pos_app   = pos_q;
        err_d     = err_q;
        if (ack_in) begin
            if (!contig) begin
                err_d = 1'b1;
            end else if (ones != '0) begin
                store_app = store_q | (data_ext << (int'(pos_q) * UnitW));
                pos_app   = pos_q + PosW'(ones);
            end
        end
        store_d = store_app;
        pos_d   = pos_app;
        if (ack_out) begin
            store_d = store_app >> OutW;
            pos_d   = pos_app - ((pos_q < NOutP) ? pos_q : NOutP);
        end
    end

    // Flush FSM: drain until the store is empty, then pulse done.
    always_comb begin
        state_d      = state_q;
        flush_done_o = 1'b0;
        case (state_q)
            FlushIdle: begin
                if (flush_i) state_d = FlushDrain;
            end
            FlushDrain: begin
                if (pos_q == '0) begin
                    flush_done_o = !rst_i;
                    state_d      = FlushIdle;
                end
            end
            default: state_d = FlushIdle;
        endcase
    end

    // State, store and sticky error registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FlushIdle;
            store_q <= '0;
            pos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_prim_packer_v2.sv
// Bench for prim_packer_v2 (32/32/8): directed vector table, a reset-mid-drain
// sequence, then randomized traffic against a unit-queue reference model.
module tb_prim_packer_v2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1, valid_i = 1'b0, flush_i = 1'b0, ready_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [3:0]  mask_i = '0;
    logic        ready_o, valid_o, last_o, flush_done_o, empty_o, err_o;
    logic [31:0] data_o;
    logic [3:0]  mask_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prim_packer_v2 #(.InW(32), .OutW(32), .UnitW(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .mask_i       (mask_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .mask_o       (mask_o),
        .last_o       (last_o),
        .ready_i      (ready_i),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .empty_o      (empty_o),
        .err_o        (err_o)
    );

    typedef struct {
        logic        rst, vld, flush, rdy;
        logic [3:0]  msk;
        logic [31:0] dat;
        logic        e_rdy, e_vld, e_last, e_done, e_empty, e_err;
        logic [3:0]  e_mask;
        logic [31:0] e_data;
    } vec_t;

    // ctl = {rst,valid,flush,ready_i}; flg = {ready,valid,last,done,empty,err}
    function automatic vec_t v(input logic [3:0] ctl, input logic [3:0] msk,
                               input logic [31:0] dat, input logic [5:0] flg,
                               input logic [3:0] emask, input logic [31:0] edata);
        vec_t r;
        {r.rst, r.vld, r.flush, r.rdy} = ctl;
        r.msk = msk;
        r.dat = dat;
        {r.e_rdy, r.e_vld, r.e_last, r.e_done, r.e_empty, r.e_err} = flg;
        r.e_mask = emask;
        r.e_data = edata;
        return r;
    endfunction

    // Observed outputs: {ready,valid,last,done,empty,err,mask,data}
    function automatic logic [41:0] obs();
        return {ready_o, valid_o, last_o, flush_done_o, empty_o, err_o, mask_o, data_o};
    endfunction

    task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual={rdy,vld,last,done,empty,err,mask,data}=%h required=%h",
                     name, $time, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input string nm);
        @(negedge clk);
        rst_i = x.rst; valid_i = x.vld; flush_i = x.flush; ready_i = x.rdy;
        mask_i = x.msk; data_i = x.dat;
        #2;
        chk(nm, obs(), {x.e_rdy, x.e_vld, x.e_last, x.e_done, x.e_empty, x.e_err,
                        x.e_mask, x.e_data});
    endtask

    // Reference model: a FIFO of stored units plus drain/error flags.
    logic [7:0] mq[$];
    bit         m_drain = 1'b0;
    bit         m_err = 1'b0;

    function automatic logic [41:0] model_obs();
        logic [31:0] d = '0;
        logic [3:0]  m = '0;
        int n = mq.size();
        bit rdy, vld, lst, dn, emp;
        if (rst_i) return {6'b000010, 4'h0, 32'h0};
        for (int i = 0; i < 4 && i < n; i++) begin
            d[i*8 +: 8] = mq[i];
            m[i] = 1'b1;
        end
        rdy = !m_drain && n <= 4;
        vld = n >= 4 || (m_drain && n != 0);
        lst = vld && m_drain && n <= 4;
        dn  = m_drain && n == 0;
        emp = n == 0;
        return {rdy, vld, lst, dn, emp, m_err, m, d};
    endfunction

    task automatic model_step();
        int n = mq.size();
        bit rdy = !m_drain && n <= 4;
        bit vld = n >= 4 || (m_drain && n != 0);
        if (rst_i) begin
            mq.delete();
            m_drain = 1'b0;
            m_err = 1'b0;
            return;
        end
        if (valid_i && rdy) begin
            int lo = -1, hi = -1;
            bit ok = 1'b1;
            for (int i = 0; i < 4; i++) if (mask_i[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
            if (lo >= 0) for (int i = lo; i <= hi; i++) if (!mask_i[i]) ok = 1'b0;
            if (!ok) m_err = 1'b1;
            else for (int i = 0; i < 4; i++) if (mask_i[i]) mq.push_back(data_i[i*8 +: 8]);
        end
        if (vld && ready_i) for (int i = 0; i < 4 && i < n; i++) void'(mq.pop_front());
        if (!m_drain && flush_i) m_drain = 1'b1;
        else if (m_drain && n == 0) m_drain = 1'b0;
    endtask

    vec_t tbl[$];
    vec_t hand[$];

    initial begin
        // merge, backpressure, flush remnant, empty flush, flush+beat, masks, reset
        tbl.push_back(v(4'b1001, 4'h0, 32'h0,        6'b000010, 4'h0, 32'h0));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b100010, 4'h0, 32'h0));
        tbl.push_back(v(4'b0101, 4'h3, 32'h0000BBAA, 6'b100010, 4'h0, 32'h0));
        tbl.push_back(v(4'b0101, 4'hC, 32'hDDCC0000, 6'b100000, 4'h3, 32'h0000BBAA));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b110000, 4'hF, 32'hDDCCBBAA));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b100010, 4'h0, 32'h0));
        tbl.push_back(v(4'b0100, 4'hF, 32'h44332211, 6'b100010, 4'h0, 32'h0));
        tbl.push_back(v(4'b0100, 4'h3, 32'h00006655, 6'b110000, 4'hF, 32'h44332211));
        tbl.push_back(v(4'b0100, 4'hF, 32'h99999999, 6'b010000, 4'hF, 32'h44332211));
        tbl.push_back(v(4'b0000, 4'h0, 32'h0,        6'b010000, 4'hF, 32'h44332211));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b010000, 4'hF, 32'h44332211));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b100000, 4'h3, 32'h00006655));
        tbl.push_back(v(4'b0100, 4'h1, 32'h00000077, 6'b100000, 4'h3, 32'h00006655));
        tbl.push_back(v(4'b0010, 4'h0, 32'h0,        6'b100000, 4'h7, 32'h00776655));
        tbl.push_back(v(4'b0000, 4'h0, 32'h0,        6'b011000, 4'h7, 32'h00776655));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b011000, 4'h7, 32'h00776655));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b000110, 4'h0, 32'h0));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b100010, 4'h0, 32'h0));
        tbl.push_back(v(4'b0011, 4'h0, 32'h0,        6'b100010, 4'h0, 32'h0));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b000110, 4'h0, 32'h0));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b100010, 4'h0, 32'h0));
        tbl.push_back(v(4'b0110, 4'h3, 32'h0000BBAA, 6'b100010, 4'h0, 32'h0));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b011000, 4'h3, 32'h0000BBAA));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b000110, 4'h0, 32'h0));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b100010, 4'h0, 32'h0));
        tbl.push_back(v(4'b0101, 4'h0, 32'hFFFFFFFF, 6'b100010, 4'h0, 32'h0));
        tbl.push_back(v(4'b0101, 4'h5, 32'h11223344, 6'b100010, 4'h0, 32'h0));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b100011, 4'h0, 32'h0));
        tbl.push_back(v(4'b0101, 4'h1, 32'h000000EE, 6'b100011, 4'h0, 32'h0));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b100001, 4'h1, 32'h000000EE));
        tbl.push_back(v(4'b1001, 4'h0, 32'h0,        6'b000010, 4'h0, 32'h0));
        tbl.push_back(v(4'b0001, 4'h0, 32'h0,        6'b100010, 4'h0, 32'h0));

        // reset while draining three units: no done pulse afterwards
        hand.push_back(v(4'b0100, 4'h7, 32'h00332211, 6'b100010, 4'h0, 32'h0));
        hand.push_back(v(4'b0010, 4'h0, 32'h0,        6'b100000, 4'h7, 32'h00332211));
        hand.push_back(v(4'b0000, 4'h0, 32'h0,        6'b011000, 4'h7, 32'h00332211));
        hand.push_back(v(4'b1000, 4'h0, 32'h0,        6'b000010, 4'h0, 32'h0));
        hand.push_back(v(4'b0000, 4'h0, 32'h0,        6'b100010, 4'h0, 32'h0));
        hand.push_back(v(4'b0000, 4'h0, 32'h0,        6'b100010, 4'h0, 32'h0));

        rst_i = 1'b1;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
        foreach (hand[i]) apply(hand[i], $sformatf("rst_drain%0d", i));

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst_i   = (c < 2) || ($urandom_range(0, 299) == 0);
            valid_i = 1'($urandom_range(0, 1));
            flush_i = ($urandom_range(0, 19) == 0);
            ready_i = ($urandom_range(0, 3) != 0);
            data_i  = $urandom();
            if ($urandom_range(0, 4) != 0) begin
                int lo = $urandom_range(0, 3);
                int len = $urandom_range(1, 4 - lo);
                mask_i = 4'(((1 << len) - 1) << lo);
            end else begin
                mask_i = 4'($urandom_range(0, 15));
            end
            #2;
            chk($sformatf("rand%0d", c), obs(), model_obs());
            @(posedge clk);
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
